// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : imm_gen_pipe                                                    |
// | Brief  : RV32I/RV64I immediate decoder with an output FIFO behind        |
// |          valid/ready handshakes, plus a saturating illegal-opcode count. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
  localparam logic [2:0] FMT_Z    = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [31:0]     imm32;     // immediate already sign/zero-extended to 32 bits
  logic            sx;        // extend imm32[31] into the upper XLEN-32 bits
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [2:0]       fmt_mem [DEPTH];
  logic             ill_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Immediate decode; unsupported opcodes yield a zero immediate and the illegal flag.
  always_comb begin
    imm32   = '0;
    sx      = 1'b0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = {in_inst[31:12], 12'b0};
        sx      = 1'b1;
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
        sx      = 1'b1;
      end
      OP_JALR, OP_LOAD: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        sx      = 1'b1;
      end
      OP_IMM: begin
        if (is_shift) begin
          dec_fmt = FMT_SH;
          // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one
          if (XLEN == 64) imm32 = {26'b0, in_inst[25:20]};
          else            imm32 = {27'b0, in_inst[24:20]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
          sx      = 1'b1;
        end
      end
      OP_IMM32: begin
        if (XLEN != 64) begin
          dec_ill = 1'b1;
        end else if (is_shift) begin
          dec_fmt = FMT_SH;
          imm32   = {27'b0, in_inst[24:20]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
          sx      = 1'b1;
        end
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        sx      = 1'b1;
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        sx      = 1'b1;
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec_fmt = FMT_Z;
          imm32   = {27'b0, in_inst[19:15]};
        end
      end
      OP_OP, OP_FENCE: begin
        dec_fmt = FMT_NONE;
      end
      OP_OP32: begin
        if (XLEN != 64) dec_ill = 1'b1;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_imm = XLEN'({{32{sx & imm32[31]}}, imm32});

  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // FIFO pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head presents zeros when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem[i] <= '0;
        fmt_mem[i] <= '0;
        ill_mem[i] <= 1'b0;
        tag_mem[i] <= '0;
      end
    end else if (push && !flush) begin
      imm_mem[wr_ptr] <= dec_imm;
      fmt_mem[wr_ptr] <= dec_fmt;
      ill_mem[wr_ptr] <= dec_ill;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  // Saturating count of accepted illegal instructions; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      illegal_cnt <= '0;
    end else if (push && !flush && dec_ill && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  assign out_imm     = imm_mem[rd_ptr];
  assign out_fmt     = fmt_mem[rd_ptr];
  assign out_illegal = ill_mem[rd_ptr];
  assign out_tag     = tag_mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_imm_gen_pipe                                                 |
// | Brief  : Scoreboard bench for imm_gen_pipe (XLEN=32 and XLEN=64 copies). |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, cnt_clr, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_tag, out_imm, out_tag;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        w_valid, w_ready, w_out_valid, w_illegal;
  logic [31:0] w_inst, w_tag;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;
  logic [15:0] w_cnt;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_tag(out_tag), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .cnt_clr(1'b0),
    .in_valid(w_valid), .in_ready(w_ready), .in_inst(w_inst), .in_tag(32'd0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_imm(w_imm), .out_fmt(w_fmt),
    .out_illegal(w_illegal), .out_tag(w_tag), .illegal_cnt(w_cnt)
  );

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] tag_n = 32'd1;
  logic [15:0] saved_cnt;

  // Hand-computed directed vectors for the XLEN=32 instance.
  logic [31:0] v_inst [11] = '{32'hFFDFF0EF, 32'h12345037, 32'hFE000FE3, 32'h40F0D093,
                               32'h0002D073, 32'h00A00093, 32'hFE112E23, 32'h002081B3,
                               32'h0000001B, 32'h00000010, 32'h0000000F};
  logic [31:0] v_imm  [11] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFE, 32'h0000000F,
                               32'h00000005, 32'h0000000A, 32'hFFFFFFFC, 32'h00000000,
                               32'h00000000, 32'h00000000, 32'h00000000};
  logic [2:0]  v_fmt  [11] = '{3'd5, 3'd4, 3'd3, 3'd6, 3'd7, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
  logic        v_ill  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected progress", name);
  endtask

  // Monitor: every accepted output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        timeout("unexpected_output");
      end else begin
        head = sb.pop_front();
        check("imm", {32'd0, out_imm}, {32'd0, head.imm});
        check("fmt", {61'd0, out_fmt}, {61'd0, head.fmt});
        check("illegal", {63'd0, out_illegal}, {63'd0, head.ill});
        check("tag", {32'd0, out_tag}, {32'd0, head.tag});
      end
    end
  end

  // Offer one instruction; record the expectation at the accepting edge.
  task automatic push(input logic [31:0] inst, input logic [31:0] imm,
                      input logic [2:0] fmt, input logic ill);
    int n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag_n;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      timeout("push_wait");
    end else begin
      @(posedge clk);
      sb.push_back('{imm, fmt, ill, tag_n});
      #1;
    end
    in_valid = 1'b0;
    tag_n    = tag_n + 32'd1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) timeout("drain");
  endtask

  task automatic push64(input logic [31:0] inst, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill);
    w_valid = 1'b1;
    w_inst  = inst;
    @(posedge clk); #1;
    w_valid = 1'b0;
    check("x64_valid", {63'd0, w_out_valid}, 64'd1);
    check("x64_imm", w_imm, imm);
    check("x64_fmt", {61'd0, w_fmt}, {61'd0, fmt});
    check("x64_illegal", {63'd0, w_illegal}, {63'd0, ill});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0; w_valid = 1'b0; w_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_imm", {32'd0, out_imm}, 64'd0);
    check("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
    check("rst_out_tag", {32'd0, out_tag}, 64'd0);
    check("rst_illegal_cnt", {48'd0, illegal_cnt}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode table with a free-running consumer
    out_ready = 1'b1;
    push(v_inst[0], v_imm[0], v_fmt[0], v_ill[0]);
    check("latency_out_valid", {63'd0, out_valid}, 64'd1);
    for (int i = 1; i < 11; i++) push(v_inst[i], v_imm[i], v_fmt[i], v_ill[i]);
    drain();
    check("cnt_after_table", {48'd0, illegal_cnt}, 64'd2);

    // XLEN=64 decode
    push64(32'h8000003B, 64'h0, 3'd0, 1'b0);
    push64(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    push64(32'h0200D093, 64'd32, 3'd6, 1'b0);
    push64(32'h0010109B, 64'd1, 3'd6, 1'b0);
    push64(32'hFFDFF0EF, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);

    // Backpressure: two entries fill the FIFO, the third waits for a pop
    out_ready = 1'b0;
    push(32'h00100093, 32'd1, 3'd1, 1'b0);
    push(32'h00200093, 32'd2, 3'd1, 1'b0);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    fork
      push(32'h00300093, 32'd3, 3'd1, 1'b0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("held_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal counter: increment, clear priority, saturation
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    repeat (3) push(32'h0, 32'h0, 3'd0, 1'b1);
    drain();
    check("cnt_three", {48'd0, illegal_cnt}, 64'd3);
    cnt_clr = 1'b1;
    push(32'h0, 32'h0, 3'd0, 1'b1);
    cnt_clr = 1'b0;
    check("cnt_clr_priority", {48'd0, illegal_cnt}, 64'd0);
    for (int i = 0; i < 65535; i++) push(32'h0, 32'h0, 3'd0, 1'b1);
    drain();
    check("cnt_reach_max", {48'd0, illegal_cnt}, 64'hFFFF);
    push(32'h0, 32'h0, 3'd0, 1'b1);
    drain();
    check("cnt_saturate", {48'd0, illegal_cnt}, 64'hFFFF);

    // Flush with a same-cycle illegal push: discarded and not counted
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    out_ready = 1'b0;
    push(32'h00A00093, 32'd10, 3'd1, 1'b0);
    saved_cnt = illegal_cnt;
    in_valid = 1'b1; in_inst = 32'h0; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    sb.delete();
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_cnt", {48'd0, illegal_cnt}, {48'd0, saved_cnt});
    push(32'h00100093, 32'd1, 3'd1, 1'b0);
    push(32'h00200093, 32'd2, 3'd1, 1'b0);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    sb.delete();
    check("flush_full_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    push(32'h12345037, 32'h12345000, 3'd4, 1'b0);
    drain();

    // Asynchronous reset in the middle of a cycle
    out_ready = 1'b0;
    push(32'h0, 32'h0, 3'd0, 1'b1);
    push(32'h0, 32'h0, 3'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_cnt", {48'd0, illegal_cnt}, 64'd0);
    check("arst_out_tag", {32'd0, out_tag}, 64'd0);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'hFE000FE3, 32'hFFFFFFFE, 3'd3, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount, CSR-immediate) into a clean XLEN-wide value, with no high-impedance bits. Results are buffered in a small output FIFO behind valid/ready handshakes. It flags illegal opcodes and counts them. It sits between fetch and the decode/execute register stage.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64.
DEPTH, 2, output FIFO entries; power of two, at least 2.
TAG_W, 32, width of the sideband tag (typically the PC) carried alongside each instruction.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
flush  in  1  synchronous FIFO clear.
cnt_clr  in  1  synchronous clear of the illegal counter.
in_valid  in  1  input instruction valid.
in_ready  out  1  FIFO can accept an instruction.
in_inst  in  32  instruction word.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  head entry valid.
out_ready  in  1  consumer accepts the head entry.
out_imm  out  XLEN  decoded immediate.
out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH, 7 Z.
out_illegal  out  1  instruction has an unsupported opcode.
out_tag  out  TAG_W  tag of the head entry.
illegal_cnt  out  16  saturating count of accepted illegal instructions.

Behaviour:
- Decode (combinational on in_inst, opcode = inst[6:0]; sext means sign-extend to XLEN):
  - LUI 0110111 / AUIPC 0010111: U; sext({inst[31:12],12'b0}).
  - JAL 1101111: J; sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: I; sext(inst[31:20]).
  - OP-IMM with funct3 001 or 101: SH instead of I; zero-extended shamt, inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
  - OP-IMM-32 0011011: with XLEN=64, I, or SH (inst[24:20]) for funct3 001/101; with XLEN=32, illegal.
  - STORE 0100011: S; sext({inst[31:25],inst[11:7]}).
  - BRANCH 1100011: B; sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - SYSTEM 1110011 with funct3[2]=1: Z; zero-extended inst[19:15]. Other SYSTEM, OP 0110011, OP-32 (XLEN=64 only), FENCE 0001111: NONE, imm 0.
  - Anything else, including inst[1:0]!=2'b11: NONE, imm 0, illegal=1.
- Handshake:
  - Push when in_valid && in_ready; pop when out_valid && out_ready.
  - in_ready = (count < DEPTH). It has no combinational dependence on out_ready, so there is no push into a full FIFO even if a pop occurs the same cycle.
  - out_valid = (count != 0). out_* present the head entry and are stable while out_valid && !out_ready.
- Latency: an instruction pushed at edge N is visible on out_* in cycle N+1 when the FIFO was empty; otherwise it appears in FIFO order.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and pointers wrap modulo DEPTH.
- flush: on the next edge count=0 and pointers=0. It overrides any same-cycle push or pop; the pushed instruction is discarded and is not counted.
- illegal_cnt:
  - Increments on each accepted push with illegal=1, and saturates at 0xFFFF.
  - cnt_clr takes priority over an increment.
  - flush does not affect the counter.
- Reset (rst_n low, any time including mid-stream):
  - count=0 and pointers=0, so out_valid=0 and in_ready=1 as soon as reset is released.
  - illegal_cnt=0.
  - FIFO data registers are reset to 0, so out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.

Test Plan:
- XLEN=32, out_ready=1, push 0xFFDFF0EF (jal x1,-4) -> next cycle out_imm=0xFFFFFFFC, out_fmt=5. Push 0x12345037 (lui) -> out_imm=0x12345000, out_fmt=4.
- Push 0xFE000FE3 (beq -2) -> out_imm=0xFFFFFFFE, fmt=3. Push 0x40F0D093 (srai x1,x1,15) -> imm=0x0000000F, fmt=6. Push 0x0002D073 (csrrwi x0,0,5) -> imm=5, fmt=7.
- XLEN=64: push 0x8000003B (OP-32) -> fmt 0, not illegal. Push 0x800000B7 (lui) -> imm=0xFFFFFFFF80000000. With XLEN=32, push 0x0000001B -> out_illegal=1.
- DEPTH=2, out_ready=0, offer three instructions back-to-back:
  - in_ready drops after two pushes; the third is held.
  - Raise out_ready: entries emerge in order, one per cycle.
  - The third is accepted the cycle after in_ready returns.
- Push 0x00000000 three times -> out_illegal=1 each time and illegal_cnt=3. cnt_clr together with a fourth illegal push -> illegal_cnt=0. Force 0xFFFF, push one more illegal -> remains 0xFFFF.
- Fill 2 entries, assert flush together with in_valid -> out_valid=0 next cycle and illegal_cnt unchanged. Refill, pulse rst_n low mid-cycle -> out_valid=0 and in_ready=1 immediately (asynchronous), and illegal_cnt=0.
